regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rd_port.sv | 42 ++++
 rtl/regfile_mp.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state enum and default widths for the multi-port register file
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read mux with zero/enable gating
// Same-cycle write forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              ready_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
`ifdef REGFILE_BYPASS_EN
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  always_comb begin
    rdata_o = '0;
    if (ready_i && en_i && (addr_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
      // Port 1 wins over port 0, matching the commit priority of the array.
      if (we1_i && (waddr1_i == addr_i)) begin
        rdata_o = wdata1_i;
      end else if (we0_i && (waddr0_i == addr_i)) begin
        rdata_o = wdata0_i;
      end else begin
        rdata_o = mem_data_i;
      end
`else
      rdata_o = mem_data_i;
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2-write, NUM_RD-read register file with sweep clear after reset/flush
// Optional same-cycle read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr0_en;
  logic wr1_en;

  assign wr1_en = (state_q == READY) && we1 && (waddr1 != '0);
  assign wr0_en = (state_q == READY) && we0 && (waddr0 != '0) &&
                  !(wr1_en && (waddr1 == waddr0));

  assign ready = ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          // Held clr_req is ignored here so the sweep always runs to completion.
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; it is zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (wr0_en) mem_q[waddr0] <= wdata0;
      if (wr1_en) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rd (
      .ready_i   (ready_q),
      .en_i      (re[k]),
      .addr_i    (raddr[k*ADDR_W +: ADDR_W]),
      .mem_data_i(mem_q[raddr[k*ADDR_W +: ADDR_W]]),
`ifdef REGFILE_BYPASS_EN
      .we0_i     (we0),
      .waddr0_i  (waddr0),
      .wdata0_i  (wdata0),
      .we1_i     (we1),
      .waddr1_i  (waddr1),
      .wdata1_i  (wdata1),
`endif
      .rdata_o   (rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule
